// File: rtl/usb_rx_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_packet_parser
// Purpose  : Splits the USB RX byte stream into PID, token fields and payload.
//            Checks the PID complement and CRC5, strips the CRC bytes, and
//            issues one done/err verdict per packet.
//            Optional CRC16 check is enabled by defining USB_CRC16_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_packet_parser #(
  parameter int MAX_PAYLOAD = 1024
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_eop,
  input  logic       rx_err,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       tok_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [2:0] err_code
);

  localparam int            CW        = $clog2(MAX_PAYLOAD + 3);
  localparam logic [CW-1:0] c_cnt_ovf = CW'(MAX_PAYLOAD + 2);
  localparam logic [2:0]    c_err_none  = 3'd0;
  localparam logic [2:0]    c_err_pid   = 3'd1;
  localparam logic [2:0]    c_err_crc5  = 3'd2;
  localparam logic [2:0]    c_err_len   = 3'd4;
  localparam logic [2:0]    c_err_rx    = 3'd5;
  localparam logic [2:0]    c_err_ovf   = 3'd6;
  localparam logic [2:0]    c_err_unsup = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TOKEN = 3'd1,
    S_DATA  = 3'd2,
    S_HSK   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Serial CRC5 over one byte, LSB first (x^5+x^2+1).
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'h05;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [7:0]    r_dly0, w_dly0, r_dly1, w_dly1;
  logic [15:0]   r_tok, w_tok;
  logic [4:0]    r_crc5, w_crc5;
  logic [2:0]    r_err, w_err, w_fin;
  logic [3:0]    r_pid, w_pid;
  logic          r_pid_valid, w_pid_valid;
  logic [6:0]    r_tok_addr, w_tok_addr;
  logic [3:0]    r_tok_endp, w_tok_endp;
  logic          r_tok_valid, w_tok_valid;
  logic [7:0]    r_data_out, w_data_out;
  logic          r_data_valid, w_data_valid;
  logic          r_pkt_done, w_pkt_done;
  logic          r_pkt_err, w_pkt_err;
  logic [2:0]    r_err_code, w_err_code;

`ifdef USB_CRC16_CHECK_EN
  localparam logic [2:0] c_err_crc16 = 3'd3;
  logic [15:0] r_crc16, w_crc16;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dly0       <= '0;
      r_dly1       <= '0;
      r_tok        <= '0;
      r_crc5       <= '0;
      r_err        <= '0;
      r_pid        <= '0;
      r_pid_valid  <= 1'b0;
      r_tok_addr   <= '0;
      r_tok_endp   <= '0;
      r_tok_valid  <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_err    <= 1'b0;
      r_err_code   <= '0;
`ifdef USB_CRC16_CHECK_EN
      r_crc16      <= '0;
`endif
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_dly0       <= w_dly0;
      r_dly1       <= w_dly1;
      r_tok        <= w_tok;
      r_crc5       <= w_crc5;
      r_err        <= w_err;
      r_pid        <= w_pid;
      r_pid_valid  <= w_pid_valid;
      r_tok_addr   <= w_tok_addr;
      r_tok_endp   <= w_tok_endp;
      r_tok_valid  <= w_tok_valid;
      r_data_out   <= w_data_out;
      r_data_valid <= w_data_valid;
      r_pkt_done   <= w_pkt_done;
      r_pkt_err    <= w_pkt_err;
      r_err_code   <= w_err_code;
`ifdef USB_CRC16_CHECK_EN
      r_crc16      <= w_crc16;
`endif
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_dly0       = r_dly0;
    w_dly1       = r_dly1;
    w_tok        = r_tok;
    w_crc5       = r_crc5;
    w_err        = r_err;
    w_fin        = c_err_none;
    w_pid        = r_pid;
    w_pid_valid  = 1'b0;
    w_tok_addr   = r_tok_addr;
    w_tok_endp   = r_tok_endp;
    w_tok_valid  = 1'b0;
    w_data_out   = r_data_out;
    w_data_valid = 1'b0;
    w_pkt_done   = 1'b0;
    w_pkt_err    = 1'b0;
    w_err_code   = r_err_code;
`ifdef USB_CRC16_CHECK_EN
    w_crc16      = r_crc16;
`endif

    // The byte is consumed first so that an EOP in the same cycle sees it.
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          w_cnt  = '0;
          w_crc5 = 5'h1F;
          w_err  = c_err_none;
`ifdef USB_CRC16_CHECK_EN
          w_crc16 = 16'hFFFF;
`endif
          if (rx_data[7:4] != ~rx_data[3:0]) begin
            w_state = S_DRAIN;
            w_err   = c_err_pid;
          end else begin
            w_pid       = rx_data[3:0];
            w_pid_valid = 1'b1;
            casez (rx_data[3:0])
              4'b??01, 4'b0100: w_state = S_TOKEN;
              4'b??11:          w_state = S_DATA;
              4'b??10:          w_state = S_HSK;
              default: begin
                w_state = S_DRAIN;
                w_err   = c_err_unsup;
              end
            endcase
          end
        end
        S_TOKEN: begin
          w_tok  = {rx_data, r_tok[15:8]};
          w_crc5 = crc5_byte(r_crc5, rx_data);
          if (r_cnt < CW'(3)) w_cnt = r_cnt + 1'b1;
        end
        S_DATA: begin
`ifdef USB_CRC16_CHECK_EN
          w_crc16 = crc16_byte(r_crc16, rx_data);
`endif
          if (r_cnt == c_cnt_ovf) begin
            w_state = S_DRAIN;
            w_err   = c_err_ovf;
          end else begin
            w_cnt = r_cnt + 1'b1;
            if (r_cnt >= CW'(2)) begin
              w_data_out   = r_dly1;
              w_data_valid = 1'b1;
            end
            w_dly1 = r_dly0;
            w_dly0 = rx_data;
          end
        end
        S_HSK:   w_cnt = CW'(1);
        default: ;
      endcase
    end

    if (rx_err && (r_state != S_IDLE)) begin
      w_state      = S_DRAIN;
      w_err        = c_err_rx;
      w_data_valid = 1'b0;
      w_data_out   = r_data_out;
    end

    if (rx_eop && (w_state != S_IDLE)) begin
      w_fin = w_err;
      if (w_err == c_err_none) begin
        case (w_state)
          S_TOKEN: begin
            if (w_cnt != CW'(2))         w_fin = c_err_len;
            else if (w_crc5 != 5'b01100) w_fin = c_err_crc5;
          end
          S_DATA: begin
            if (w_cnt < CW'(2))            w_fin = c_err_len;
`ifdef USB_CRC16_CHECK_EN
            else if (w_crc16 != 16'h800D) w_fin = c_err_crc16;
`endif
          end
          S_HSK:   if (w_cnt != '0) w_fin = c_err_len;
          default: ;
        endcase
      end
      if (w_fin == c_err_none) begin
        w_pkt_done = 1'b1;
        if (w_state == S_TOKEN) begin
          w_tok_valid = 1'b1;
          w_tok_addr  = w_tok[6:0];
          w_tok_endp  = w_tok[10:7];
        end
      end else begin
        w_pkt_err  = 1'b1;
        w_err_code = w_fin;
      end
      w_state = S_IDLE;
    end
  end

  assign pid        = r_pid;
  assign pid_valid  = r_pid_valid;
  assign tok_addr   = r_tok_addr;
  assign tok_endp   = r_tok_endp;
  assign tok_valid  = r_tok_valid;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign pkt_done   = r_pkt_done;
  assign pkt_err    = r_pkt_err;
  assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_packet_parser
// Purpose  : Scoreboard bench for usb_rx_packet_parser (MAX_PAYLOAD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_packet_parser;

  localparam int K_PID  = 0;
  localparam int K_TOK  = 1;
  localparam int K_DAT  = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  typedef struct {
    int          kind;
    logic [10:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pkt_q[$];
  int         checks   = 0;
  int         failures = 0;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_eop = 1'b0;
  logic       rx_err = 1'b0;
  logic [3:0] pid;
  logic       pid_valid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       tok_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_done;
  logic       pkt_err;
  logic [2:0] err_code;

  usb_rx_packet_parser #(.MAX_PAYLOAD(4)) dut (
    .clk(clk), .nRST(nRST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_eop(rx_eop), .rx_err(rx_err), .pid(pid), .pid_valid(pid_valid),
    .tok_addr(tok_addr), .tok_endp(tok_endp), .tok_valid(tok_valid),
    .data_out(data_out), .data_valid(data_valid), .pkt_done(pkt_done),
    .pkt_err(pkt_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_PID:   return "pid";
      K_TOK:   return "token";
      K_DAT:   return "data";
      K_DONE:  return "done";
      default: return "err";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input logic [10:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [10:0] act);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected: actual=%h required=nothing", kname(kind), act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== act) begin
        failures++;
        $display("FAIL %s: actual=%h required %s=%h", kname(kind), act, kname(e.kind), e.val);
      end
    end
  endtask

  // Monitor: every output strobe is matched against the expected queue.
  always @(negedge clk) begin
    if (nRST) begin
      if (pid_valid)  check_ev(K_PID, {7'd0, pid});
      if (tok_valid)  check_ev(K_TOK, {tok_endp, tok_addr});
      if (data_valid) check_ev(K_DAT, {3'd0, data_out});
      if (pkt_done)   check_ev(K_DONE, 11'd0);
      if (pkt_err)    check_ev(K_ERR, {8'd0, err_code});
    end
  end

  task automatic cyc(input logic [7:0] d, input logic v, input logic e, input logic er);
    @(negedge clk);
    rx_data  = d;
    rx_valid = v;
    rx_eop   = e;
    rx_err   = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends pkt_q, optionally with an idle gap after each byte, then EOP.
  task automatic send_pkt(input bit gaps);
    foreach (pkt_q[i]) begin
      cyc(pkt_q[i], 1'b1, 1'b0, 1'b0);
      if (gaps) idle(1);
    end
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    idle(3);
  endtask

  task automatic expect_data(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) expect_ev(K_DAT, {3'd0, first + 8'(i)});
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    idle(2);
    check_val("reset_outputs",
              {5'd0, pid, pid_valid, tok_addr, tok_endp, tok_valid, data_out,
               data_valid, pkt_done, pkt_err, err_code}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    idle(2);

    // ACK, EOP in a later cycle
    expect_ev(K_PID, 11'h2); expect_ev(K_DONE, 11'd0);
    pkt_q = {8'hD2}; send_pkt(1'b1);

    // ACK with PID byte and EOP in the same cycle
    expect_ev(K_PID, 11'h2); expect_ev(K_DONE, 11'd0);
    cyc(8'hD2, 1'b1, 1'b1, 1'b0); idle(3);

    // Bare EOP while idle: nothing must come out
    cyc(8'h00, 1'b0, 1'b1, 1'b0); idle(3);

    // IN token addr 0x15 endp 0xE, valid CRC5
    expect_ev(K_PID, 11'h9); expect_ev(K_TOK, 11'h715); expect_ev(K_DONE, 11'd0);
    pkt_q = {8'h69, 8'h15, 8'hEF}; send_pkt(1'b1);

    // Same token with CRC bit 15 flipped
    expect_ev(K_PID, 11'h9); expect_ev(K_ERR, 11'd2);
    pkt_q = {8'h69, 8'h15, 8'h6F}; send_pkt(1'b1);

    // Short token
    expect_ev(K_PID, 11'h9); expect_ev(K_ERR, 11'd4);
    pkt_q = {8'h69, 8'h15}; send_pkt(1'b0);

    // DATA0 with 4 payload bytes (exactly MAX_PAYLOAD) and valid CRC16
    expect_ev(K_PID, 11'h3); expect_data(8'h00, 4); expect_ev(K_DONE, 11'd0);
    pkt_q = {8'hC3, 8'h00, 8'h01, 8'h02, 8'h03, 8'hEF, 8'h7A}; send_pkt(1'b1);

    // DATA0 with corrupted CRC16
    expect_ev(K_PID, 11'h3); expect_data(8'h00, 4);
`ifdef USB_CRC16_CHECK_EN
    expect_ev(K_ERR, 11'd3);
`else
    expect_ev(K_DONE, 11'd0);
`endif
    pkt_q = {8'hC3, 8'h00, 8'h01, 8'h02, 8'h03, 8'hEF, 8'h7B}; send_pkt(1'b0);

    // DATA1 zero-length payload
    expect_ev(K_PID, 11'hB); expect_ev(K_DONE, 11'd0);
    pkt_q = {8'h4B, 8'h00, 8'h00}; send_pkt(1'b1);

    // DATA0 with a single byte after PID
    expect_ev(K_PID, 11'h3); expect_ev(K_ERR, 11'd4);
    pkt_q = {8'hC3, 8'h00}; send_pkt(1'b1);

    // PID complement failure, following bytes ignored
    expect_ev(K_ERR, 11'd1);
    pkt_q = {8'hC1, 8'h00, 8'h11}; send_pkt(1'b1);

    // Reserved PID 1000
    expect_ev(K_PID, 11'h8); expect_ev(K_ERR, 11'd7);
    pkt_q = {8'h78, 8'h00}; send_pkt(1'b1);

    // Handshake with a trailing byte
    expect_ev(K_PID, 11'h2); expect_ev(K_ERR, 11'd4);
    pkt_q = {8'hD2, 8'h00}; send_pkt(1'b1);

    // DATA1 with 5 payload bytes overflows MAX_PAYLOAD=4
    expect_ev(K_PID, 11'hB); expect_data(8'h10, 4); expect_ev(K_ERR, 11'd6);
    pkt_q = {8'h4B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'hA5, 8'h5A}; send_pkt(1'b0);

    // rx_err mid-packet
    expect_ev(K_PID, 11'h3); expect_ev(K_DAT, 11'hAA); expect_ev(K_ERR, 11'd5);
    cyc(8'hC3, 1'b1, 1'b0, 1'b0); cyc(8'hAA, 1'b1, 1'b0, 1'b0);
    cyc(8'hBB, 1'b1, 1'b0, 1'b0); cyc(8'hCC, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b1); cyc(8'hDD, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0); idle(3);

    // rx_err overrides a pending PID error
    expect_ev(K_ERR, 11'd5);
    cyc(8'hC1, 1'b1, 1'b0, 1'b0); cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1, 1'b0); idle(3);

    // Reset mid-packet: no verdict, outputs cleared, next byte is a PID
    expect_ev(K_PID, 11'h3); expect_ev(K_DAT, 11'h01);
    cyc(8'hC3, 1'b1, 1'b0, 1'b0); cyc(8'h01, 1'b1, 1'b0, 1'b0);
    cyc(8'h02, 1'b1, 1'b0, 1'b0); cyc(8'h03, 1'b1, 1'b0, 1'b0);
    idle(2);
    nRST = 1'b0;
    idle(2);
    check_val("midreset_clear", {21'd0, pid, err_code, data_out}, 32'd0);
    nRST = 1'b1;
    expect_ev(K_PID, 11'h2); expect_ev(K_DONE, 11'd0);
    pkt_q = {8'hD2}; send_pkt(1'b0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing %s: actual=none required=%h", kname(e.kind), e.val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
